// File: rtl/movement_controller.sv
// rtl/movement_controller.sv - grid movement sequencer around the combinational collision detector
module movement_controller #(
    parameter int START_X         = 1,
    parameter int START_Y         = 1,
    parameter int EXIT_X          = 18,
    parameter int EXIT_Y          = 13,
    parameter int SETTLE_CYCLES   = 2,
    parameter int COOLDOWN_CYCLES = 12500000,
    parameter int CD_W            = 24
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            move_req,
    input  logic [2:0]      move_dir,
    input  logic [4:0]      det_new_x,
    input  logic [4:0]      det_new_y,
    output logic [4:0]      det_x,
    output logic [4:0]      det_y,
    output logic [2:0]      det_move,
    output logic [1:0]      det_map,
    output logic [4:0]      pos_x,
    output logic [4:0]      pos_y,
    output logic [1:0]      map_sel,
    output logic            move_ack,
    output logic            moved,
    output logic            blocked,
    output logic            map_changed,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_QUERY    = 2'd1;
    localparam logic [1:0] ST_COMMIT   = 2'd2;
    localparam logic [1:0] ST_COOLDOWN = 2'd3;

    localparam logic [4:0]      START_X5    = 5'(START_X);
    localparam logic [4:0]      START_Y5    = 5'(START_Y);
    localparam logic [4:0]      EXIT_X5     = 5'(EXIT_X);
    localparam logic [4:0]      EXIT_Y5     = 5'(EXIT_Y);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD     = CD_W'(COOLDOWN_CYCLES - 1);

    logic [1:0]      state;
    logic [3:0]      settle_cnt;
    logic [CD_W-1:0] cd_cnt;
    logic            dir_valid;
    logic            at_exit;
    logic            pos_differs;

    always_comb begin
        dir_valid = 1'b0;
        case (move_dir)
            3'b100, 3'b001, 3'b010, 3'b011: dir_valid = 1'b1;
            default:                        dir_valid = 1'b0;
        endcase
    end

    assign at_exit     = (det_new_x == EXIT_X5) && (det_new_y == EXIT_Y5);
    assign pos_differs = (det_new_x != pos_x) || (det_new_y != pos_y);

    // The detector is purely combinational, so it always sees the committed position.
    assign det_x   = pos_x;
    assign det_y   = pos_y;
    assign det_map = map_sel;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            cd_cnt      <= '0;
            det_move    <= 3'b000;
            pos_x       <= START_X5;
            pos_y       <= START_Y5;
            map_sel     <= 2'd0;
            move_ack    <= 1'b0;
            moved       <= 1'b0;
            blocked     <= 1'b0;
            map_changed <= 1'b0;
        end else begin
            move_ack    <= 1'b0;
            moved       <= 1'b0;
            blocked     <= 1'b0;
            map_changed <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (move_req && dir_valid) begin
                        det_move   <= move_dir;
                        move_ack   <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_QUERY;
                    end
                end
                ST_QUERY: begin
                    if (settle_cnt == 4'd0) begin
                        state <= ST_COMMIT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_COMMIT: begin
                    det_move <= 3'b000;
                    cd_cnt   <= CD_LOAD;
                    state    <= ST_COOLDOWN;
                    // Exit takes priority: the player is respawned on the next map.
                    if (at_exit) begin
                        pos_x       <= START_X5;
                        pos_y       <= START_Y5;
                        map_sel     <= map_sel + 2'd1;
                        map_changed <= 1'b1;
                        moved       <= 1'b1;
                    end else if (pos_differs) begin
                        pos_x <= det_new_x;
                        pos_y <= det_new_y;
                        moved <= 1'b1;
                    end else begin
                        blocked <= 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_movement_controller.sv
// tb/tb_movement_controller.sv - directed vector bench for movement_controller
module tb_movement_controller;

    logic       clk;
    logic       resetn;
    logic       move_req;
    logic [2:0] move_dir;
    logic [4:0] det_new_x;
    logic [4:0] det_new_y;
    logic [4:0] det_x;
    logic [4:0] det_y;
    logic [2:0] det_move;
    logic [1:0] det_map;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [1:0] map_sel;
    logic       move_ack;
    logic       moved;
    logic       blocked;
    logic       map_changed;
    logic       busy;

    int checks;
    int errors;

    movement_controller #(
        .START_X(1), .START_Y(1), .EXIT_X(18), .EXIT_Y(13),
        .SETTLE_CYCLES(1), .COOLDOWN_CYCLES(4), .CD_W(24)
    ) dut (
        .clk(clk), .resetn(resetn), .move_req(move_req), .move_dir(move_dir),
        .det_new_x(det_new_x), .det_new_y(det_new_y), .det_x(det_x), .det_y(det_y),
        .det_move(det_move), .det_map(det_map), .pos_x(pos_x), .pos_y(pos_y),
        .map_sel(map_sel), .move_ack(move_ack), .moved(moved), .blocked(blocked),
        .map_changed(map_changed), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] dir;
        logic [4:0] nx;
        logic [4:0] ny;
        logic       ack;
        logic       mv;
        logic       blk;
        logic       mc;
        logic [4:0] ex;
        logic [4:0] ey;
        logic [1:0] em;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey, input int em);
        chk({name, " pos_x"}, pos_x, ex);
        chk({name, " pos_y"}, pos_y, ey);
        chk({name, " map_sel"}, map_sel, em);
        chk({name, " det_x"}, det_x, ex);
        chk({name, " det_y"}, det_y, ey);
        chk({name, " det_map"}, det_map, em);
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        logic [4:0] ox, oy;
        logic [1:0] om;
        tag = $sformatf("vec%0d", idx);
        ox = pos_x; oy = pos_y; om = map_sel;
        @(negedge clk);
        move_req  = 1'b1;
        move_dir  = v.dir;
        det_new_x = v.nx;
        det_new_y = v.ny;
        @(posedge clk); #1;
        chk({tag, " ack"}, move_ack, v.ack);
        chk({tag, " busy after req"}, busy, v.ack);
        @(negedge clk);
        move_req = 1'b0;
        if (v.ack) begin
            move_dir = 3'b010;
            @(posedge clk); #1;
            chk({tag, " det_move held"}, det_move, v.dir);
            chk({tag, " no early moved"}, moved, 0);
            chk({tag, " pos before commit"}, {pos_x, pos_y}, {ox, oy});
            @(posedge clk); #1;
            chk({tag, " moved"}, moved, v.mv);
            chk({tag, " blocked"}, blocked, v.blk);
            chk({tag, " map_changed"}, map_changed, v.mc);
            chk({tag, " det_move cleared"}, det_move, 0);
            repeat (3) @(posedge clk);
            #1 chk({tag, " busy in cooldown"}, busy, 1);
            @(posedge clk); #1;
            chk({tag, " idle after cooldown"}, busy, 0);
        end else begin
            repeat (2) @(posedge clk);
            #1 chk({tag, " busy stays low"}, busy, 0);
            chk({tag, " det_move idle"}, det_move, 0);
        end
        chk_pos(tag, v.ex, v.ey, v.em);
        if (!v.ack) chk({tag, " map unchanged"}, map_sel, om);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        move_req = 1'b0; move_dir = 3'b000;
        det_new_x = 5'd1; det_new_y = 5'd1;

        //            dir     nx     ny    ack   mv    blk   mc    ex     ey     em
        tbl[0]  = '{3'b001, 5'd1,  5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 5'd1,  5'd1,  2'd0};
        tbl[1]  = '{3'b100, 5'd2,  5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  5'd1,  2'd0};
        tbl[2]  = '{3'b000, 5'd3,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  5'd1,  2'd0};
        tbl[3]  = '{3'b101, 5'd3,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  5'd1,  2'd0};
        tbl[4]  = '{3'b111, 5'd3,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  5'd1,  2'd0};
        tbl[5]  = '{3'b011, 5'd2,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  5'd2,  2'd0};
        tbl[6]  = '{3'b100, 5'd18, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1,  5'd1,  2'd1};
        tbl[7]  = '{3'b100, 5'd18, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1,  5'd1,  2'd2};
        tbl[8]  = '{3'b100, 5'd17, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 5'd13, 2'd2};
        tbl[9]  = '{3'b100, 5'd18, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1,  5'd1,  2'd3};
        tbl[10] = '{3'b100, 5'd17, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 5'd17, 5'd13, 2'd3};
        tbl[11] = '{3'b100, 5'd18, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1,  5'd1,  2'd0};
        tbl[12] = '{3'b010, 5'd0,  5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  5'd1,  2'd0};
        tbl[13] = '{3'b011, 5'd0,  5'd1,  1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd1,  2'd0};

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_pos("reset", 1, 1, 0);
        chk("reset busy", busy, 0);
        chk("reset det_move", det_move, 0);
        chk("reset pulses", {move_ack, moved, blocked, map_changed}, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) apply(tbl[i], i);

        // Level-held request: dropped during cooldown, re-accepted exactly 7 edges later.
        @(negedge clk);
        move_req = 1'b1; move_dir = 3'b100;
        det_new_x = 5'd1; det_new_y = 5'd1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold ack edge%0d", k), move_ack, (k == 1 || k == 8) ? 1 : 0);
            if (k == 3) begin
                chk("hold moved", moved, 1);
                chk_pos("hold commit", 1, 1, 0);
            end
            if (k == 7) chk("hold idle before reaccept", busy, 0);
            if (k >= 2 && k <= 6) chk($sformatf("hold busy edge%0d", k), busy, 1);
        end
        @(negedge clk);
        move_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reaccept blocked", blocked, 1);
        chk_pos("reaccept", 1, 1, 0);
        repeat (4) @(posedge clk);
        #1 chk("reaccept idle", busy, 0);

        // Reset during QUERY aborts the move.
        @(negedge clk);
        move_req = 1'b1; move_dir = 3'b100;
        det_new_x = 5'd5; det_new_y = 5'd5;
        @(posedge clk); #1;
        chk("abort ack", move_ack, 1);
        @(negedge clk);
        resetn = 1'b0; move_req = 1'b0;
        #1;
        chk_pos("abort reset", 1, 1, 0);
        chk("abort busy", busy, 0);
        chk("abort det_move", det_move, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("abort quiet%0d", k), {move_ack, moved, blocked, map_changed, busy}, 0);
        end
        chk_pos("abort after", 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
